// File: rtl/pipe_mux_nx1_pkg.sv
// rtl/pipe_mux_nx1_pkg.sv - shared constants and selector-width helper for operand selectors
package pipe_mux_nx1_pkg;

  // Native PA-RISC datapath width
  localparam int DEFAULT_WIDTH = 32;

  // Smallest selector width that can address n_in inputs (at least one bit)
  function automatic int sel_width(input int n_in);
    return (n_in > 1) ? $clog2(n_in) : 1;
  endfunction

endpackage

// File: rtl/mux_nx1_comb.sv
// rtl/mux_nx1_comb.sv - combinational N:1 selector with out-of-range select flag
module mux_nx1_comb
  import pipe_mux_nx1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_IN  = 4,
  parameter int SEL_W = sel_width(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data,
  output logic                  err
);

  // Scan every input so an unused selector code falls through to zero data with err set
  always_comb begin
    data = '0;
    err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (int'(sel) == k) begin
        data = in_data[k*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_mux_nx1.sv
// rtl/pipe_mux_nx1.sv - registered N:1 operand selector with valid/ready and one-entry skid buffer
module pipe_mux_nx1
  import pipe_mux_nx1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_IN  = 4,
  parameter int SEL_W = sel_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sel_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;

  // Main register drives the outputs; skid register catches one beat while stalled
  logic [WIDTH-1:0] m_data;
  logic             m_err;
  logic             m_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_err;
  logic             s_valid;

  logic in_xfer;
  logic m_free;

  mux_nx1_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_sel (
    .in_data (in_data),
    .sel     (sel),
    .data    (mux_data),
    .err     (mux_err)
  );

  // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
  assign in_ready = ~s_valid;
  assign in_xfer  = in_valid & ~s_valid;
  assign m_free   = ~m_valid | out_ready;

  // Advance main/skid registers on transfers; reset beats flush, flush drops everything
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      m_data  <= '0;
      m_err   <= 1'b0;
      m_valid <= 1'b0;
      s_data  <= '0;
      s_err   <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_free) begin
      if (s_valid) begin
        m_data  <= s_data;
        m_err   <= s_err;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (in_xfer) begin
        m_data  <= mux_data;
        m_err   <= mux_err;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      s_data  <= mux_data;
      s_err   <= mux_err;
      s_valid <= 1'b1;
    end
  end

  assign out_data    = m_data;
  assign out_sel_err = m_err;
  assign out_valid   = m_valid;

endmodule
